avalon_mem_rd_rsp_buffer: RTL and testbench

// AFU-side stage ahead of the Avalon-MM register pipeline toward local memory. Adds a read-response

---
 rtl/avalon_mem_rd_rsp_buffer_if.sv | 25 ++
 rtl/avalon_mem_rd_rsp_buffer.sv | 57 +++++
 tb/tb_avalon_mem_rd_rsp_buffer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/avalon_mem_rd_rsp_buffer_if.sv
// avalon_mem_rd_rsp_buffer_if: AFU-side and memory-side Avalon-MM signals of the read-response buffer
interface avalon_mem_rd_rsp_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int BURST_CNT_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] s_address, m_address;
  logic s_read, s_write, s_waitrequest, m_read, m_write, m_waitrequest;
  logic [BURST_CNT_WIDTH-1:0] s_burstcount, m_burstcount;
  logic [DATA_WIDTH-1:0] s_writedata, m_writedata, s_rsp_data, m_readdata;
  logic [DATA_WIDTH/8-1:0] s_byteenable, m_byteenable;
  logic s_rsp_valid, s_rsp_ready, m_readdatavalid;
  modport slave (
    input s_address, s_read, s_write, s_burstcount, s_writedata, s_byteenable, s_rsp_ready,
          m_waitrequest, m_readdata, m_readdatavalid,
    output s_waitrequest, s_rsp_valid, s_rsp_data,
           m_address, m_read, m_write, m_burstcount, m_writedata, m_byteenable
  );
  modport master (
    output s_address, s_read, s_write, s_burstcount, s_writedata, s_byteenable, s_rsp_ready,
           m_waitrequest, m_readdata, m_readdatavalid,
    input s_waitrequest, s_rsp_valid, s_rsp_data,
          m_address, m_read, m_write, m_burstcount, m_writedata, m_byteenable
  );
endinterface

// File: rtl/avalon_mem_rd_rsp_buffer.sv
// avalon_mem_rd_rsp_buffer: read-response FIFO with whole-burst credit reservation ahead of Avalon-MM memory
module avalon_mem_rd_rsp_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int BURST_CNT_WIDTH = 4,
  parameter int RSP_BUF_DEPTH = 64
) (
  input logic clk,
  input logic reset_n,
  avalon_mem_rd_rsp_buffer_if.slave bus
);
  localparam int PW = $clog2(RSP_BUF_DEPTH);
  localparam int CW = PW + 1;
  logic [CW-1:0] reserved_q, reserved_d, wr_q, wr_d, rd_q, rd_d;
  logic [DATA_WIDTH-1:0] mem_q [RSP_BUF_DEPTH];
  logic credit_ok, issue, push, pop, valid;
  // reserved counts beats still in flight downstream plus beats parked in the FIFO
  assign credit_ok = (RSP_BUF_DEPTH - int'(reserved_q)) >= int'(bus.s_burstcount);
  assign valid = wr_q != rd_q;
  assign issue = bus.m_read & ~bus.m_waitrequest;
  assign push = bus.m_readdatavalid;
  assign pop = valid & bus.s_rsp_ready;
  assign bus.m_read = bus.s_read & credit_ok;
  assign bus.m_write = bus.s_write;
  assign bus.m_address = ADDR_WIDTH'(bus.s_address);
  assign bus.m_burstcount = BURST_CNT_WIDTH'(bus.s_burstcount);
  assign bus.m_writedata = DATA_WIDTH'(bus.s_writedata);
  assign bus.m_byteenable = (DATA_WIDTH/8)'(bus.s_byteenable);
  assign bus.s_waitrequest = bus.m_waitrequest | (bus.s_read & ~credit_ok);
  assign bus.s_rsp_valid = valid;
  assign bus.s_rsp_data = valid ? mem_q[rd_q[PW-1:0]] : '0;
  always_comb begin
    reserved_d = reserved_q + (issue ? CW'(bus.s_burstcount) : '0) - CW'(pop);
    wr_d = wr_q + CW'(push);
    rd_d = rd_q + CW'(pop);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      reserved_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      reserved_q <= reserved_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q[PW-1:0]] <= bus.m_readdata;
  assert property (@(posedge clk) disable iff (!reset_n) bus.s_read |-> bus.s_burstcount != '0)
    else $error("read issued with zero burstcount");
  assert property (@(posedge clk) disable iff (!reset_n) !(bus.s_read && bus.s_write))
    else $error("read and write requested together");
  assert property (@(posedge clk) disable iff (!reset_n) push |-> reserved_q != wr_q - rd_q)
    else $error("readdatavalid with no read outstanding");
  assert property (@(posedge clk) disable iff (!reset_n) push |-> (wr_q - rd_q) != CW'(RSP_BUF_DEPTH))
    else $fatal(1, "response fifo overflow");
endmodule

// File: tb/tb_avalon_mem_rd_rsp_buffer.sv
// tb_avalon_mem_rd_rsp_buffer: directed and random reads/writes against a queue-based credit/FIFO model
module tb_avalon_mem_rd_rsp_buffer;
  localparam int DEPTH = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  int outst = 0;
  logic [31:0] fifo_q[$];
  logic [31:0] ret_q[$];
  avalon_mem_rd_rsp_buffer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .BURST_CNT_WIDTH(4)) b ();
  avalon_mem_rd_rsp_buffer #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .BURST_CNT_WIDTH(4), .RSP_BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(rst_n), .bus(b)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: drive at negedge, check combinational view, then advance the model at posedge
  task automatic cyc(input bit rd, input bit wr, input int bc, input bit rdy, input bit mw, input bit rdv);
    bit cr, iss, pop, dv;
    int res;
    dv = rdv && ret_q.size() != 0;
    b.s_read = rd;
    b.s_write = wr;
    b.s_burstcount = 4'(bc);
    b.s_address = 10'($urandom);
    b.s_writedata = $urandom;
    b.s_byteenable = 4'($urandom);
    b.s_rsp_ready = rdy;
    b.m_waitrequest = mw;
    b.m_readdatavalid = dv;
    b.m_readdata = dv ? ret_q[0] : $urandom;
    #1;
    res = outst + fifo_q.size();
    cr = (DEPTH - res) >= bc;
    chk("m_read", b.m_read, rd && cr);
    chk("s_waitrequest", b.s_waitrequest, mw || (rd && !cr));
    chk("m_write", b.m_write, wr);
    chk("m_address", b.m_address, b.s_address);
    chk("m_writedata", b.m_writedata, b.s_writedata);
    chk("s_rsp_valid", b.s_rsp_valid, fifo_q.size() != 0);
    if (fifo_q.size() != 0) chk("s_rsp_data", b.s_rsp_data, fifo_q[0]);
    chk("reserved", 32'(dut.reserved_q), res);
    iss = rd && cr && !mw;
    pop = fifo_q.size() != 0 && rdy;
    @(posedge clk);
    if (pop) void'(fifo_q.pop_front());
    if (dv) begin
      fifo_q.push_back(ret_q.pop_front());
      outst--;
    end
    if (iss) begin
      repeat (bc) ret_q.push_back($urandom);
      outst += bc;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    repeat (40) cyc(0, 0, 1, 1, 0, 1);
  endtask

  initial begin
    b.s_read = 0; b.s_write = 0; b.s_burstcount = 4'd1; b.s_address = '0;
    b.s_writedata = '0; b.s_byteenable = '0; b.s_rsp_ready = 0;
    b.m_waitrequest = 0; b.m_readdata = 32'hdead_beef; b.m_readdatavalid = 1;
    #1;
    chk("reset valid", b.s_rsp_valid, 0);
    chk("reset data", b.s_rsp_data, 0);
    chk("reset reserved", 32'(dut.reserved_q), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("valid ignores rdv in reset", b.s_rsp_valid, 0);
    b.m_readdatavalid = 0;
    rst_n = 1;
    // single burst-4 read returned back-to-back with ready high
    cyc(1, 0, 4, 1, 0, 0);
    repeat (4) cyc(0, 0, 1, 1, 0, 1);
    repeat (2) cyc(0, 0, 1, 1, 0, 0);
    // two burst-8 reads fill the buffer; the third waits until 8 beats are popped
    cyc(1, 0, 8, 0, 0, 0);
    cyc(1, 0, 8, 0, 0, 0);
    repeat (16) cyc(1, 0, 8, 0, 0, 1);
    repeat (9) cyc(1, 0, 8, 1, 0, 0);
    drain();
    // reserved=11: burst 8 held, burst 4 fits
    cyc(1, 0, 8, 0, 0, 0);
    cyc(1, 0, 3, 0, 0, 0);
    repeat (3) cyc(1, 0, 8, 0, 0, 1);
    cyc(1, 0, 4, 0, 0, 0);
    drain();
    // reserved=10 with one beat in flight: issue, push and pop in one cycle
    cyc(1, 0, 8, 0, 0, 0);
    cyc(1, 0, 2, 0, 0, 0);
    repeat (9) cyc(0, 0, 1, 0, 0, 1);
    cyc(1, 0, 4, 1, 0, 1);
    repeat (3) cyc(0, 0, 1, 1, 0, 1);
    drain();
    // credits exhausted: writes still pass, downstream stall still propagates
    cyc(1, 0, 8, 0, 0, 0);
    cyc(1, 0, 8, 0, 0, 0);
    cyc(0, 1, 2, 0, 0, 0);
    cyc(0, 1, 2, 0, 1, 0);
    cyc(1, 0, 1, 0, 1, 0);
    drain();
    // asynchronous reset mid-burst
    cyc(1, 0, 8, 0, 0, 0);
    repeat (3) cyc(0, 0, 1, 0, 0, 1);
    #2 rst_n = 0;
    #1;
    chk("midreset valid", b.s_rsp_valid, 0);
    chk("midreset data", b.s_rsp_data, 0);
    chk("midreset reserved", 32'(dut.reserved_q), 0);
    fifo_q.delete();
    ret_q.delete();
    outst = 0;
    @(negedge clk);
    rst_n = 1;
    cyc(1, 0, 2, 1, 0, 0);
    repeat (4) cyc(0, 0, 1, 1, 0, 1);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      int k;
      k = $urandom_range(0, 3);
      cyc(k == 0, k == 1, $urandom_range(1, 8), 1'($urandom_range(0, 1)),
          $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
    end
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
